mem_uart_sender: RTL and testbench

Host-side transmitter that streams a fixed-length block of bytes from a synchronous byte memory onto a UART serial line. Framing is 8N1, LSB first. It is the sending end for the UART_MEM receive path: it loads the block that UART_MEM stores before UART_MEM echoes it back. It contains its own bit serializer and does not instantiate uart_tx.

---
 rtl/mem_uart_sender.sv | 167 ++++++++++++++++
 tb/tb_mem_uart_sender.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_uart_sender.sv
// Streams NUM_BYTES bytes from a synchronous byte memory onto an 8N1, LSB-first UART line.
// Each byte takes one FETCH and one LOAD cycle, then ten serial bits of CLKS_PER_BIT cycles.
module mem_uart_sender #(
   parameter int unsigned CLKS_PER_BIT = 100,
   parameter int unsigned NUM_BYTES    = 4096,
   parameter int unsigned ADDR_W       = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic              tx_serial,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   byte_cnt
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  CLK_ONE  = CNT_W'(1);
   localparam logic [ADDR_W:0]   NUM_CNT  = (ADDR_W + 1)'(NUM_BYTES);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StLoad,
      StStart,
      StData,
      StStop,
      StDone
   } state_e;

   state_e            r_state;
   logic [CNT_W-1:0]  r_clk_cnt;
   logic [2:0]        r_bit_idx;
   logic [7:0]        r_shift;
   logic              r_tx;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_byte_cnt;

   state_e            w_state_nx;
   logic [CNT_W-1:0]  w_clk_cnt_nx;
   logic [2:0]        w_bit_idx_nx;
   logic [7:0]        w_shift_nx;
   logic              w_tx_nx;
   logic [ADDR_W-1:0] w_addr_nx;
   logic [ADDR_W:0]   w_byte_cnt_nx;
   logic              w_bit_end;
   logic [ADDR_W:0]   w_cnt_inc;

   assign w_bit_end = (r_clk_cnt == LAST_CNT);
   assign w_cnt_inc = r_byte_cnt + CNT_ONE;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= StIdle;
         r_clk_cnt  <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_tx       <= 1'b1;
         r_addr     <= '0;
         r_byte_cnt <= '0;
      end else begin
         r_state    <= w_state_nx;
         r_clk_cnt  <= w_clk_cnt_nx;
         r_bit_idx  <= w_bit_idx_nx;
         r_shift    <= w_shift_nx;
         r_tx       <= w_tx_nx;
         r_addr     <= w_addr_nx;
         r_byte_cnt <= w_byte_cnt_nx;
      end
   end

   always_comb begin
      w_state_nx    = r_state;
      w_clk_cnt_nx  = r_clk_cnt;
      w_bit_idx_nx  = r_bit_idx;
      w_shift_nx    = r_shift;
      w_tx_nx       = r_tx;
      w_addr_nx     = r_addr;
      w_byte_cnt_nx = r_byte_cnt;

      unique case (r_state)
         StIdle: begin
            w_tx_nx = 1'b1;
            if (start) begin
               w_state_nx    = StFetch;
               w_addr_nx     = '0;
               w_byte_cnt_nx = '0;
               w_clk_cnt_nx  = '0;
               w_bit_idx_nx  = '0;
            end
         end
         StFetch: begin
            w_state_nx = StLoad;
         end
         StLoad: begin
            // Read data is valid only in this cycle; the start bit is registered here too.
            w_shift_nx   = mem_rdata;
            w_tx_nx      = 1'b0;
            w_clk_cnt_nx = '0;
            w_state_nx   = StStart;
         end
         StStart: begin
            if (w_bit_end) begin
               w_clk_cnt_nx = '0;
               w_bit_idx_nx = '0;
               w_tx_nx      = r_shift[0];
               w_shift_nx   = {1'b0, r_shift[7:1]};
               w_state_nx   = StData;
            end else begin
               w_clk_cnt_nx = r_clk_cnt + CLK_ONE;
            end
         end
         StData: begin
            if (w_bit_end) begin
               w_clk_cnt_nx = '0;
               if (r_bit_idx == 3'd7) begin
                  w_tx_nx    = 1'b1;
                  w_state_nx = StStop;
               end else begin
                  w_bit_idx_nx = r_bit_idx + 3'd1;
                  w_tx_nx      = r_shift[0];
                  w_shift_nx   = {1'b0, r_shift[7:1]};
               end
            end else begin
               w_clk_cnt_nx = r_clk_cnt + CLK_ONE;
            end
         end
         StStop: begin
            if (w_bit_end) begin
               w_clk_cnt_nx  = '0;
               w_byte_cnt_nx = w_cnt_inc;
               // Last byte leaves the address at NUM_BYTES-1 so a full-size block never wraps.
               if (w_cnt_inc < NUM_CNT) begin
                  w_addr_nx  = r_addr + ADDR_ONE;
                  w_state_nx = StFetch;
               end else begin
                  w_state_nx = StDone;
               end
            end else begin
               w_clk_cnt_nx = r_clk_cnt + CLK_ONE;
            end
         end
         StDone: begin
            w_state_nx = StIdle;
         end
         default: begin
            w_state_nx = StIdle;
            w_tx_nx    = 1'b1;
         end
      endcase
   end

   assign mem_rd_en = (r_state == StFetch);
   assign mem_addr  = r_addr;
   assign tx_serial = r_tx;
   assign busy      = (r_state != StIdle) && (r_state != StDone);
   assign done      = (r_state == StDone);
   assign byte_cnt  = r_byte_cnt;

endmodule

// File: tb/tb_mem_uart_sender.sv
// Bench for mem_uart_sender: cycle-exact line/strobe model plus a sampling UART receiver,
// with a second small instance covering a block that fills the whole address space.
module tb_mem_uart_sender;

   localparam int C     = 4;
   localparam int N     = 3;
   localparam int AW    = 4;
   localparam int P     = 10 * C + 2;
   localparam int TOTAL = N * P + 1;
   localparam int TAIL  = 4;

   localparam int C2 = 2;
   localparam int N2 = 4;
   localparam int AW2 = 2;
   localparam int P2 = 10 * C2 + 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic start2 = 1'b0;

   logic          mem_rd_en, tx_serial, busy, done;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_rdata;
   logic [AW:0]   byte_cnt;

   logic           mem_rd_en2, tx_serial2, busy2, done2;
   logic [AW2-1:0] mem_addr2;
   logic [7:0]     mem_rdata2;
   logic [AW2:0]   byte_cnt2;

   logic [7:0] mem  [0:15];
   logic [7:0] mem2 [0:3];
   logic       obs  [1:TOTAL+TAIL];

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] d0;
      logic [7:0] d1;
      logic [7:0] d2;
      bit         rnd;
      int         extra_k;
      int         exp_done_k;
      int         exp_cnt;
   } vec_t;

   vec_t vecs [0:9];

   mem_uart_sender #(.CLKS_PER_BIT(C), .NUM_BYTES(N), .ADDR_W(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .mem_rd_en(mem_rd_en),
      .mem_addr (mem_addr),
      .mem_rdata(mem_rdata),
      .tx_serial(tx_serial),
      .busy     (busy),
      .done     (done),
      .byte_cnt (byte_cnt)
   );

   mem_uart_sender #(.CLKS_PER_BIT(C2), .NUM_BYTES(N2), .ADDR_W(AW2)) dut_full (
      .clk      (clk),
      .rst      (rst),
      .start    (start2),
      .mem_rd_en(mem_rd_en2),
      .mem_addr (mem_addr2),
      .mem_rdata(mem_rdata2),
      .tx_serial(tx_serial2),
      .busy     (busy2),
      .done     (done2),
      .byte_cnt (byte_cnt2)
   );

   always #5 clk = ~clk;

   // Synchronous memories; garbage outside read cycles shows rdata is sampled only when valid.
   always @(posedge clk) begin
      mem_rdata  <= mem_rd_en  ? mem[mem_addr]   : 8'($urandom);
      mem_rdata2 <= mem_rd_en2 ? mem2[mem_addr2] : 8'($urandom);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected line level k cycles after start acceptance.
   function automatic logic model_tx(input int k);
      int b, off, j;
      if (k > N * P) return 1'b1;
      b   = (k - 1) / P;
      off = (k - 1) % P;
      if (off < 2) return 1'b1;
      j = (off - 2) / C;
      if (j == 0) return 1'b0;
      if (j == 9) return 1'b1;
      return mem[4'(b)][3'(j - 1)];
   endfunction

   task automatic run_block(input int extra_k, input int exp_done_k, input int exp_cnt);
      int   done_cnt = 0;
      int   done_at  = -1;
      int   nb       = 0;
      int   i        = 1;
      logic [7:0] rx;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= TOTAL + TAIL; k++) begin
         @(negedge clk);
         start = 1'b0;
         check("tx_serial", 32'(tx_serial), 32'(model_tx(k)));
         check("busy", 32'(busy), 32'(k <= N * P));
         check("done", 32'(done), 32'(k == TOTAL));
         check("mem_rd_en", 32'(mem_rd_en), 32'(k <= N * P && (k - 1) % P == 0));
         if (k <= N * P && (k - 1) % P == 0) check("mem_addr", 32'(mem_addr), 32'((k - 1) / P));
         check("byte_cnt", 32'(byte_cnt), (k <= N * P) ? 32'((k - 1) / P) : 32'(N));
         if (k >= TOTAL) check("mem_addr_hold", 32'(mem_addr), 32'(N - 1));
         if (done === 1'b1) begin
            done_cnt++;
            done_at = k;
         end
         obs[k] = tx_serial;
         if (k == extra_k) start = 1'b1;
      end
      check("done_cycle", 32'(done_at), 32'(exp_done_k));
      check("done_count", 32'(done_cnt), 32'd1);
      check("final_byte_cnt", 32'(byte_cnt), 32'(exp_cnt));
      // Receiver: find each start bit, sample mid-bit.
      while (i + 10 * C - 1 <= TOTAL + TAIL) begin
         if (obs[i] === 1'b0) begin
            for (int j = 0; j < 8; j++) rx[j] = obs[i + C * (j + 1) + C / 2];
            check("rx_stop", 32'(obs[i + 9 * C + C / 2]), 32'd1);
            if (nb < N) check("rx_byte", 32'(rx), 32'(mem[4'(nb)]));
            nb++;
            i += 10 * C;
         end else begin
            i++;
         end
      end
      check("rx_count", 32'(nb), 32'(N));
   endtask

   task automatic run_full_block();
      int   nxt = 0;
      int   dcnt = 0;
      for (int b = 0; b < N2; b++) mem2[2'(b)] = 8'($urandom);
      @(negedge clk);
      start2 = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= N2 * P2 + 3; k++) begin
         @(negedge clk);
         start2 = 1'b0;
         if (mem_rd_en2 === 1'b1) begin
            check("full_addr", 32'(mem_addr2), 32'(nxt));
            nxt++;
         end
         check("full_done", 32'(done2), 32'(k == N2 * P2 + 1));
         if (done2 === 1'b1) dcnt++;
      end
      check("full_reads", 32'(nxt), 32'(N2));
      check("full_done_count", 32'(dcnt), 32'd1);
      check("full_last_addr", 32'(mem_addr2), 32'(N2 - 1));
      check("full_byte_cnt", 32'(byte_cnt2), 32'(N2));
      check("full_busy", 32'(busy2), 32'd0);
   endtask

   logic [9:0] frame_a3;

   initial begin
      vecs[0] = '{8'h55, 8'hA3, 8'hFF, 1'b0, 0,         TOTAL, N};
      vecs[1] = '{8'h00, 8'h00, 8'h00, 1'b1, P + 18,    TOTAL, N};
      vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b1, TOTAL,     TOTAL, N};
      vecs[3] = '{8'h00, 8'hFF, 8'h01, 1'b0, 20,        TOTAL, N};
      for (int r = 4; r < 10; r++)
         vecs[r] = '{8'h00, 8'h00, 8'h00, 1'b1, int'($urandom_range(1, TOTAL)), TOTAL, N};
      frame_a3 = 10'b1101000110;
      for (int a = 0; a < 16; a++) mem[4'(a)] = 8'h00;
      for (int a = 0; a < 4; a++) mem2[2'(a)] = 8'h00;

      // Reset held, then idle with no start.
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("rst_tx", 32'(tx_serial), 32'd1);
         check("rst_busy", 32'(busy), 32'd0);
         check("rst_addr", 32'(mem_addr), 32'd0);
         check("rst_cnt", 32'(byte_cnt), 32'd0);
      end
      rst = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         check("idle_tx", 32'(tx_serial), 32'd1);
         check("idle_busy", 32'(busy), 32'd0);
         check("idle_done", 32'(done), 32'd0);
         check("idle_rd_en", 32'(mem_rd_en), 32'd0);
      end

      for (int v = 0; v < 10; v++) begin
         if (vecs[v].rnd) begin
            for (int b = 0; b < N; b++) mem[4'(b)] = 8'($urandom);
         end else begin
            mem[0] = vecs[v].d0;
            mem[1] = vecs[v].d1;
            mem[2] = vecs[v].d2;
         end
         run_block(vecs[v].extra_k, vecs[v].exp_done_k, vecs[v].exp_cnt);
         if (v == 0) begin
            check("gap_stop", 32'(obs[P]), 32'd1);
            check("gap_fetch", 32'(obs[P + 1]), 32'd1);
            check("gap_load", 32'(obs[P + 2]), 32'd1);
            for (int j = 0; j < 10; j++)
               check("frame_a3", 32'(obs[P + 3 + C * j + C / 2]), 32'(frame_a3[j]));
         end
      end

      // Mid-frame reset during a zero data bit of byte 1.
      mem[0] = 8'hC3;
      mem[1] = 8'h00;
      mem[2] = 8'h5A;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (P + 2 + 2 * C) @(negedge clk);
      check("pre_rst_tx", 32'(tx_serial), 32'd0);
      check("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("async_rst_tx", 32'(tx_serial), 32'd1);
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_rd_en", 32'(mem_rd_en), 32'd0);
      check("async_rst_addr", 32'(mem_addr), 32'd0);
      check("async_rst_cnt", 32'(byte_cnt), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_tx", 32'(tx_serial), 32'd1);
      for (int b = 0; b < N; b++) mem[4'(b)] = 8'($urandom);
      run_block(0, TOTAL, N);

      run_full_block();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
